// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: default depth, byte width,
// sequencer state encoding and the status-word layout.
package uart_tx_fifo_pkg;

    localparam int unsigned UART_TX_FIFO_DEPTH_LOG2 = 4;
    localparam int unsigned BYTE_W                  = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE        = 2'd0,
        SEQ_WAIT_ACTIVE = 2'd1,
        SEQ_WAIT_DONE   = 2'd2
    } seq_state_e;

    // Fields returned to the peripheral read mux for the UART status word.
    typedef struct packed {
        logic                               full;
        logic                               empty;
        logic                               overflow;
        logic [UART_TX_FIFO_DEPTH_LOG2:0]   level;
    } tx_status_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo_byte.sv
// Byte-wide synchronous circular FIFO with level tracking and a sticky
// overflow flag; a push into a full FIFO is dropped even if a pop coincides.
module uart_tx_fifo_sync_fifo_byte
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_TX_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic                  push,
    input  logic [BYTE_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  clr_overflow,
    output logic [BYTE_W-1:0]     head_data_c,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(DEPTH);

    logic [BYTE_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      level_next_c;
    logic                  push_acc_c;
    logic                  pop_acc_c;

    assign push_acc_c  = push && !full && !sync_reset;
    assign pop_acc_c   = pop && !empty && !sync_reset;
    assign head_data_c = mem[rd_ptr];

    // Next occupancy from accepted push/pop.
    always_comb begin
        level_next_c = level;
        if (push_acc_c && !pop_acc_c) begin
            level_next_c = level + LVL_W'(1);
        end else if (!push_acc_c && pop_acc_c) begin
            level_next_c = level - LVL_W'(1);
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_acc_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, level, registered flags and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (sync_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_acc_c) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_acc_c) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            level <= level_next_c;
            full  <= (level_next_c == LEVEL_FULL);
            empty <= (level_next_c == '0);
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: queues bus writes and feeds the transmitter one
// byte at a time, pacing on the transmitter's tx_active status.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = UART_TX_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic                  wr_en,
    input  logic [BYTE_W-1:0]     wr_data,
    input  logic                  clr_overflow,
    input  logic                  tx_active,
    output logic                  start_TX,
    output logic [BYTE_W-1:0]     SBUF_out,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    seq_state_e        state;
    logic              pop_c;
    logic [BYTE_W-1:0] head_data_c;

    assign pop_c = (state == SEQ_IDLE) && !empty && !tx_active;

    uart_tx_fifo_sync_fifo_byte #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_reset   (sync_reset),
        .push         (wr_en),
        .push_data    (wr_data),
        .pop          (pop_c),
        .clr_overflow (clr_overflow),
        .head_data_c  (head_data_c),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow)
    );

    // Sequencer: pop head, pulse start_TX, then wait for a full tx_active cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SEQ_IDLE;
            start_TX <= 1'b0;
            SBUF_out <= '0;
        end else if (sync_reset) begin
            state    <= SEQ_IDLE;
            start_TX <= 1'b0;
            SBUF_out <= '0;
        end else begin
            start_TX <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (pop_c) begin
                        SBUF_out <= head_data_c;
                        start_TX <= 1'b1;
                        state    <= SEQ_WAIT_ACTIVE;
                    end
                end
                SEQ_WAIT_ACTIVE: begin
                    if (tx_active) begin
                        state <= SEQ_WAIT_DONE;
                    end
                end
                SEQ_WAIT_DONE: begin
                    if (!tx_active) begin
                        state <= SEQ_IDLE;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sync_reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_overflow;
    logic       tx_active;
    logic       start_TX;
    logic [7:0] SBUF_out;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;

    logic       tx_force;
    int         model_len;
    logic [7:0] model_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         bad_pulse = 0;
    logic       prev_start = 1'b0;
    logic [7:0] sent_q[$];
    int         sent_cyc[$];
    bit         ok;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_reset   (sync_reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .tx_active    (tx_active),
        .start_TX     (start_TX),
        .SBUF_out     (SBUF_out),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow)
    );

    // Transmitter model: busy for model_len cycles after each start pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                model_cnt <= 8'd0;
        else if (sync_reset)         model_cnt <= 8'd0;
        else if (start_TX)           model_cnt <= 8'(model_len);
        else if (model_cnt != 8'd0)  model_cnt <= model_cnt - 8'd1;
    end

    assign tx_active = tx_force | (model_cnt != 8'd0);

    always @(posedge clk) cyc <= cyc + 1;

    // Record every start pulse; flag pulses during busy or longer than one cycle.
    always @(negedge clk) begin
        if (start_TX === 1'b1) begin
            sent_q.push_back(SBUF_out);
            sent_cyc.push_back(cyc);
            if (tx_active) bad_pulse++;
            if (prev_start) bad_pulse++;
        end
        prev_start = start_TX;
    end

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        sent_q.delete();
        sent_cyc.delete();
        bad_pulse = 0;
    endtask

    task automatic wait_sent(input int n, input int budget, output bit done);
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sent_q.size() >= n) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sync_reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        clr_overflow = 1'b0; tx_force = 1'b0; model_len = 3;
        settle(2);
        n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_checks++; if (start_TX !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start_TX); end
        n_checks++; if (SBUF_out !== 8'h00) begin n_fail++; $display("FAIL reset_sbuf got %h want 00", SBUF_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        reset_n = 1'b1;
        settle(2);
    endtask

    task automatic test_single();
        model_len = 3;
        clear_log();
        wr_en = 1'b1; wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (empty !== 1'b0)   begin n_fail++; $display("FAIL single_empty got %b want 0", empty); end
        n_checks++; if (level !== 5'd1)   begin n_fail++; $display("FAIL single_level1 got %0d want 1", level); end
        n_checks++; if (start_TX !== 1'b0) begin n_fail++; $display("FAIL single_early_start got %b want 0", start_TX); end
        @(negedge clk);
        n_checks++; if (start_TX !== 1'b1) begin n_fail++; $display("FAIL single_start got %b want 1", start_TX); end
        n_checks++; if (SBUF_out !== 8'h55) begin n_fail++; $display("FAIL single_sbuf got %h want 55", SBUF_out); end
        n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL single_level0 got %0d want 0", level); end
        @(negedge clk);
        n_checks++; if (start_TX !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len got %b want 0", start_TX); end
        n_checks++; if (SBUF_out !== 8'h55) begin n_fail++; $display("FAIL single_sbuf_hold got %h want 55", SBUF_out); end
        settle(12);
        n_checks++; if (sent_q.size() !== 1) begin n_fail++; $display("FAIL single_pulse_count got %0d want 1", sent_q.size()); end
        n_checks++; if (bad_pulse !== 0)  begin n_fail++; $display("FAIL single_bad_pulse got %0d want 0", bad_pulse); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        model_len = 100;
        clear_log();
        for (int i = 0; i < 3; i++) push_byte(exp_b[i]);
        wait_sent(3, 500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout got %0d pulses want 3", sent_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (sent_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, sent_q[i], exp_b[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (sent_cyc[i] - sent_cyc[i-1] !== 103) begin
                n_fail++; $display("FAIL b2b_spacing%0d got %0d want 103", i, sent_cyc[i] - sent_cyc[i-1]);
            end
        end
        n_checks++; if (bad_pulse !== 0) begin n_fail++; $display("FAIL b2b_bad_pulse got %0d want 0", bad_pulse); end
        settle(110);
        model_len = 4;
    endtask

    task automatic test_full_overflow();
        clear_log();
        tx_force = 1'b1;
        settle(1);
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        n_checks++; if (full !== 1'b1)     begin n_fail++; $display("FAIL full_flag got %b want 1", full); end
        n_checks++; if (level !== 5'd16)   begin n_fail++; $display("FAIL full_level got %0d want 16", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_pre got %b want 0", overflow); end
        push_byte(8'hEE);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        n_checks++; if (level !== 5'd16)   begin n_fail++; $display("FAIL ovf_level got %0d want 16", level); end
        clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
        clr_overflow = 1'b1; wr_en = 1'b1; wr_data = 8'hEF;
        @(negedge clk);
        clr_overflow = 1'b0; wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
        clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
        tx_force = 1'b0;
        wait_sent(16, 400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_drain_timeout got %0d want 16", sent_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (sent_q[i] !== 8'(8'h80 + i)) begin n_fail++; $display("FAIL full_drain%0d got %h want %h", i, sent_q[i], 8'(8'h80 + i)); end
        end
        settle(12);
        n_checks++; if (empty !== 1'b1 || level !== 5'd0) begin n_fail++; $display("FAIL full_drain_empty got %b/%0d want 1/0", empty, level); end
        n_checks++; if (bad_pulse !== 0) begin n_fail++; $display("FAIL full_bad_pulse got %0d want 0", bad_pulse); end
    endtask

    task automatic test_full_pop_collision();
        clear_log();
        tx_force = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h90 + i));
        tx_force = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd15)   begin n_fail++; $display("FAIL coll_level got %0d want 15", level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL coll_ovf got %b want 1", overflow); end
        n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL coll_full got %b want 0", full); end
        n_checks++; if (start_TX !== 1'b1 || SBUF_out !== 8'h90) begin n_fail++; $display("FAIL coll_pop got %b/%h want 1/90", start_TX, SBUF_out); end
        clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
        wait_sent(16, 400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL coll_timeout got %0d want 16", sent_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (sent_q[i] !== 8'(8'h90 + i)) begin n_fail++; $display("FAIL coll_drain%0d got %h want %h", i, sent_q[i], 8'(8'h90 + i)); end
        end
        settle(12);
    endtask

    task automatic test_push_pop_same();
        clear_log();
        tx_force = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hA0 + i));
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL pp_level_pre got %0d want 5", level); end
        tx_force = 1'b0; wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL pp_level got %0d want 5", level); end
        n_checks++; if (start_TX !== 1'b1 || SBUF_out !== 8'hA0) begin n_fail++; $display("FAIL pp_pop got %b/%h want 1/a0", start_TX, SBUF_out); end
        wait_sent(6, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pp_timeout got %0d want 6", sent_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (sent_q[i] !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL pp_drain%0d got %h want %h", i, sent_q[i], 8'(8'hA0 + i)); end
        end
        settle(12);
    endtask

    task automatic test_wrap();
        clear_log();
        tx_force = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'(8'hB0 + i));
        tx_force = 1'b0;
        wait_sent(10, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap1_timeout got %0d want 10", sent_q.size()); end
        settle(12);
        tx_force = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'(8'hC0 + i));
        n_checks++; if (level !== 5'd10) begin n_fail++; $display("FAIL wrap_level got %0d want 10", level); end
        tx_force = 1'b0;
        wait_sent(20, 300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap2_timeout got %0d want 20", sent_q.size()); end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] exp_v;
            exp_v = (i < 10) ? 8'(8'hB0 + i) : 8'(8'hC0 + i - 10);
            n_checks++;
            if (sent_q[i] !== exp_v) begin n_fail++; $display("FAIL wrap_byte%0d got %h want %h", i, sent_q[i], exp_v); end
        end
        settle(12);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", empty); end
    endtask

    task automatic test_sync_reset();
        clear_log();
        tx_force = 1'b1;
        for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL srst_ovf_pre got %b want 1", overflow); end
        sync_reset = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk);
        sync_reset = 1'b0; wr_en = 1'b0;
        n_checks++; if (level !== 5'd0)    begin n_fail++; $display("FAIL srst_level got %0d want 0", level); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL srst_flags got e%b f%b want e1 f0", empty, full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL srst_ovf got %b want 0", overflow); end
        n_checks++; if (start_TX !== 1'b0 || SBUF_out !== 8'h00) begin n_fail++; $display("FAIL srst_out got %b/%h want 0/00", start_TX, SBUF_out); end

        tx_force = 1'b0; model_len = 100;
        clear_log();
        push_byte(8'hD0);
        settle(3);
        for (int i = 1; i <= 8; i++) push_byte(8'(8'hD0 + i));
        n_checks++; if (level !== 5'd8 || tx_active !== 1'b1) begin n_fail++; $display("FAIL srst_pre got %0d/%b want 8/1", level, tx_active); end
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        n_checks++; if (level !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL srst_mid got %0d/%b want 0/1", level, empty); end
        n_checks++; if (start_TX !== 1'b0) begin n_fail++; $display("FAIL srst_mid_start got %b want 0", start_TX); end
        push_byte(8'h5A);
        n_checks++; if (start_TX !== 1'b0 || empty !== 1'b0) begin n_fail++; $display("FAIL srst_new_pre got %b/%b want 0/0", start_TX, empty); end
        @(negedge clk);
        n_checks++; if (start_TX !== 1'b1 || SBUF_out !== 8'h5A) begin n_fail++; $display("FAIL srst_new got %b/%h want 1/5a", start_TX, SBUF_out); end
        settle(3);
        n_checks++; if (sent_q.size() !== 2) begin n_fail++; $display("FAIL srst_pulses got %0d want 2", sent_q.size()); end
        n_checks++; if (sent_q[1] !== 8'h5A) begin n_fail++; $display("FAIL srst_byte got %h want 5a", sent_q[1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_overflow();
        test_full_pop_collision();
        test_push_pop_same();
        test_wrap();
        test_sync_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
